trans_validator_multi: RTL and testbench
========================================

Name: trans_validator_multi

Overview:
Parametrised successor to the single-config transaction validator. It keeps a ledger of account balances in on-chip RAM and checks each incoming transfer packet against it. Accepted transfers update both balances; every transaction can be reported with a status code. Adds input/output handshakes, capacity-full detection, balance-overflow rejection, self-transfer handling, selectable reject reporting and accept/reject statistics.

Parameters:
ID_W, 48, account ID width
AMT_W, 22, transfer amount width
BAL_W, 24, stored balance width; must be >= AMT_W
DEPTH, 16384, maximum accounts held; power of two
INIT_BAL, 100, balance given to a newly created account
REPORT_REJECTS, 1, 1 = emit every transaction with status; 0 = emit accepted only
PKT_W, 2*ID_W+AMT_W+10, packet width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
data_i  in  PKT_W  packet: [PKT_W-1 -: ID_W] sender, next ID_W receiver, next AMT_W amount, [9] block_start, [8:0] passed through
valid_i  in  1  input packet valid
ready_o  out  1  block can accept a packet (high only in IDLE)
data_o  out  PKT_W  copy of the packet being reported
valid_o  out  1  report valid; held until ready_i
ready_i  in  1  downstream accepts report
status_o  out  2  0 = OK, 1 = FUNDS, 2 = FULL, 3 = OVERFLOW
acc_cnt_o  out  32  number of accepted transactions, wraps
rej_cnt_o  out  32  number of rejected transactions, wraps

Behaviour:
- Reset: ready_o=0 in the reset cycle, then 1. valid_o=0, status_o=0, data_o=0, acc/rej counters=0, account count=0, FSM=IDLE. RAM contents are not cleared; the account count masks them. Reset mid-operation aborts the transaction: no write and no report.
- Input handshake: a packet is taken when valid_i && ready_o. It is latched whole.
- block_start=1: the account count is cleared before the lookup, so the block starts an empty ledger.
- RAM: 1-cycle read latency, one write port. Entry = {ID, balance}.
- FSM:
  - IDLE: takes the packet.
  - RD: issues read addr=iter.
  - CHK: compares the returned ID to sender and receiver and records their index and balance. Goes to ALLOC when iter+1 >= count or both are found; otherwise iter++ and back to RD. With count==0, RD/CHK are skipped and the FSM goes straight to ALLOC.
  - ALLOC: counts how many accounts are missing: 0, 1 or 2; a self-transfer counts as 1. If count+new > DEPTH, status=FULL and nothing is written. Otherwise missing accounts get INIT_BAL at indices count, count+1 (sender first), and count += new.
  - EVAL: if sender_bal < amount, status=FUNDS. Else if receiver_bal + amount >= 2^BAL_W, status=OVERFLOW. Else status=OK, sender -= amount, receiver += amount.
  - WR_S, WR_R: one write each. They run on OK, and also on rejection when accounts were created, so the new accounts are persisted with unchanged balances. A self-transfer does one write with an unchanged balance.
  - RESP: valid_o=1. Holds data_o and status_o until ready_i. If REPORT_REJECTS=0 and status!=OK, RESP is skipped. acc_cnt_o or rej_cnt_o increments once per transaction, on leaving EVAL.
- Latency from accept to valid_o: 2*(entries scanned)+4 cycles minimum.
- amount=0: accepted, balances unchanged, still written.
- The count register is wide enough to hold DEPTH itself.

Test Plan:
- Reset, then packet A→B with amount 30 and block_start=1 → status OK, stored A=70, B=130, count=2, acc_cnt=1.
- Then A→B with amount 71 → status FUNDS, balances unchanged, rej_cnt=1; with REPORT_REJECTS=0 there is no valid_o pulse.
- Then C→C with amount 50 → status OK, C=100 is created, count=3, a single write occurs.
- With DEPTH=4: fill 3 accounts, then D→E → status FULL, count stays 3, no write; the next D→A → OK with D=INIT_BAL-amt.
- With BAL_W=8, INIT_BAL=200: A→B with amount 60 → OVERFLOW, both accounts created at 200.
- Hold ready_i=0 for 5 cycles → valid_o and data_o stable, ready_o=0; assert rst mid-scan → no report, count=0 afterwards.

Source files
------------

// File: rtl/trans_validator_multi_if.sv
// Packet-in / report-out handshake bundle for trans_validator_multi.
interface trans_validator_multi_if #(
  parameter int unsigned PKT_W = 128
) ();
  logic [PKT_W-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [PKT_W-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [1:0]       status_o;
  logic [31:0]      acc_cnt_o;
  logic [31:0]      rej_cnt_o;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, status_o, acc_cnt_o, rej_cnt_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, status_o, acc_cnt_o, rej_cnt_o
  );
endinterface

// File: rtl/trans_validator_multi.sv
// Transfer validator: linear scan of an on-chip account ledger, allocate missing accounts,
// check funds/overflow, write back balances and report each transaction with a status code.
module trans_validator_multi #(
  parameter int unsigned ID_W           = 48,
  parameter int unsigned AMT_W          = 22,
  parameter int unsigned BAL_W          = 24,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned INIT_BAL       = 100,
  parameter bit          REPORT_REJECTS = 1'b1,
  parameter int unsigned PKT_W          = 2 * ID_W + AMT_W + 10
) (
  input logic                   clk,
  input logic                   rst,
  trans_validator_multi_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ID_W + BAL_W;
  localparam logic [BAL_W-1:0] InitBal = BAL_W'(INIT_BAL);

  typedef enum logic [2:0] {StIdle, StRd, StChk, StAlloc, StEval, StWrS, StWrR, StResp} state_e;
  typedef enum logic [1:0] {StatOk, StatFunds, StatFull, StatOvf} status_e;

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      iter_q, iter_d;
  logic               s_found_q, s_found_d, r_found_q, r_found_d;
  logic [AW-1:0]      s_idx_q, s_idx_d, r_idx_q, r_idx_d;
  logic [BAL_W-1:0]   s_bal_q, s_bal_d, r_bal_q, r_bal_d;
  logic               full_q, full_d, created_q, created_d;
  logic [31:0]        acc_q, acc_d, rej_q, rej_d;

  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      rd_q;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [EW-1:0]      wdata;

  logic [ID_W-1:0]    snd_id, rcv_id, rd_id;
  logic [BAL_W-1:0]   amt, rd_bal;
  logic [BAL_W:0]     rcv_sum;
  logic               self_xfer;
  logic [CW-1:0]      iter_nx;
  logic [1:0]         n_new;
  logic [CW:0]        cnt_need;
  state_e             post_wr;

  assign snd_id    = pkt_q[PKT_W-1 -: ID_W];
  assign rcv_id    = pkt_q[PKT_W-1-ID_W -: ID_W];
  assign amt       = BAL_W'(pkt_q[PKT_W-1-2*ID_W -: AMT_W]);
  assign self_xfer = (snd_id == rcv_id);
  assign rd_id     = rd_q[EW-1 -: ID_W];
  assign rd_bal    = rd_q[BAL_W-1:0];
  assign rcv_sum   = {1'b0, r_bal_q} + {1'b0, amt};
  assign iter_nx   = CW'(iter_q) + CW'(1);
  // A self-transfer needs at most one new account.
  assign n_new     = self_xfer ? {1'b0, ~s_found_q}
                               : {1'b0, ~s_found_q} + {1'b0, ~r_found_q};
  assign cnt_need  = {1'b0, cnt_q} + (CW+1)'(n_new);
  assign post_wr   = (status_q == StatOk || REPORT_REJECTS) ? StResp : StIdle;

  assign bus.ready_o   = (state_q == StIdle) && !rst;
  assign bus.valid_o   = (state_q == StResp);
  assign bus.data_o    = pkt_q;
  assign bus.status_o  = status_q;
  assign bus.acc_cnt_o = acc_q;
  assign bus.rej_cnt_o = rej_q;

  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
    rd_q <= mem[iter_q];
  end

  always_comb begin
    state_d   = state_q;   status_d  = status_q;  pkt_d     = pkt_q;
    cnt_d     = cnt_q;     iter_d    = iter_q;
    s_found_d = s_found_q; r_found_d = r_found_q;
    s_idx_d   = s_idx_q;   r_idx_d   = r_idx_q;
    s_bal_d   = s_bal_q;   r_bal_d   = r_bal_q;
    full_d    = full_q;    created_d = created_q;
    acc_d     = acc_q;     rej_d     = rej_q;
    we        = 1'b0;      waddr     = '0;        wdata     = '0;
    unique case (state_q)
      StIdle: if (bus.valid_i) begin
        pkt_d     = bus.data_i;
        iter_d    = '0;
        s_found_d = 1'b0;
        r_found_d = 1'b0;
        full_d    = 1'b0;
        created_d = 1'b0;
        if (bus.data_i[9]) cnt_d = '0;
        state_d = (bus.data_i[9] || cnt_q == '0) ? StAlloc : StRd;
      end
      StRd: state_d = StChk;
      StChk: begin
        if (!s_found_q && rd_id == snd_id) begin
          s_found_d = 1'b1; s_idx_d = iter_q; s_bal_d = rd_bal;
        end
        if (!r_found_q && rd_id == rcv_id) begin
          r_found_d = 1'b1; r_idx_d = iter_q; r_bal_d = rd_bal;
        end
        if (iter_nx >= cnt_q || (s_found_d && r_found_d)) begin
          state_d = StAlloc;
        end else begin
          iter_d  = iter_q + AW'(1);
          state_d = StRd;
        end
      end
      StAlloc: begin
        if (cnt_need > (CW+1)'(DEPTH)) begin
          full_d = 1'b1;
        end else begin
          if (!s_found_q) begin
            s_idx_d = cnt_q[AW-1:0]; s_bal_d = InitBal;
          end
          if (self_xfer) begin
            r_idx_d = s_idx_d; r_bal_d = s_bal_d;
          end else if (!r_found_q) begin
            r_idx_d = s_found_q ? cnt_q[AW-1:0] : cnt_q[AW-1:0] + AW'(1);
            r_bal_d = InitBal;
          end
          cnt_d     = cnt_need[CW-1:0];
          created_d = (n_new != 2'd0);
        end
        state_d = StEval;
      end
      StEval: begin
        if (full_q || s_bal_q < amt || rcv_sum[BAL_W]) begin
          status_d = full_q ? StatFull : (s_bal_q < amt) ? StatFunds : StatOvf;
          rej_d    = rej_q + 32'd1;
          // Newly created accounts are persisted even on a rejected transfer.
          if (!full_q && created_q) state_d = StWrS;
          else                      state_d = REPORT_REJECTS ? StResp : StIdle;
        end else begin
          status_d = StatOk;
          acc_d    = acc_q + 32'd1;
          if (!self_xfer) begin
            s_bal_d = s_bal_q - amt;
            r_bal_d = r_bal_q + amt;
          end
          state_d = StWrS;
        end
      end
      StWrS: begin
        we = 1'b1; waddr = s_idx_q; wdata = {snd_id, s_bal_q};
        state_d = self_xfer ? post_wr : StWrR;
      end
      StWrR: begin
        we = 1'b1; waddr = r_idx_q; wdata = {rcv_id, r_bal_q};
        state_d = post_wr;
      end
      StResp: if (bus.ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;  status_q  <= StatOk;  pkt_q     <= '0;
      cnt_q     <= '0;      iter_q    <= '0;
      s_found_q <= 1'b0;    r_found_q <= 1'b0;
      s_idx_q   <= '0;      r_idx_q   <= '0;
      s_bal_q   <= '0;      r_bal_q   <= '0;
      full_q    <= 1'b0;    created_q <= 1'b0;
      acc_q     <= '0;      rej_q     <= '0;
    end else begin
      state_q   <= state_d;   status_q  <= status_d;  pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;     iter_q    <= iter_d;
      s_found_q <= s_found_d; r_found_q <= r_found_d;
      s_idx_q   <= s_idx_d;   r_idx_q   <= r_idx_d;
      s_bal_q   <= s_bal_d;   r_bal_q   <= r_bal_d;
      full_q    <= full_d;    created_q <= created_d;
      acc_q     <= acc_d;     rej_q     <= rej_d;
    end
  end
endmodule

// File: tb/tb_trans_validator_multi.sv
// Directed bench: three validator configurations (default, DEPTH=4 silent rejects, BAL_W=8).
module tb_trans_validator_multi;
  localparam logic [1:0] StOk = 2'd0, StFunds = 2'd1, StFull = 2'd2, StOvf = 2'd3;
  localparam logic [47:0] IdA = 48'd1, IdB = 48'd2, IdC = 48'd3, IdD = 48'd4, IdE = 48'd5;

  logic clk, rst, vin, rin, bs;
  int   sel;
  logic [47:0] snd, rcv;
  logic [21:0] amt;
  logic [8:0]  tag;
  int   n_cmp, n_fail;

  logic        o_ready, o_valid;
  logic [1:0]  o_status;
  logic [8:0]  o_tag;
  logic [47:0] o_snd;
  logic [31:0] o_acc, o_rej;

  trans_validator_multi_if #(.PKT_W(128)) if0 ();
  trans_validator_multi_if #(.PKT_W(114)) if1 ();
  trans_validator_multi_if #(.PKT_W(114)) if2 ();

  assign if0.data_i  = {snd, rcv, amt, bs, tag};
  assign if1.data_i  = {snd, rcv, amt[7:0], bs, tag};
  assign if2.data_i  = {snd, rcv, amt[7:0], bs, tag};
  assign if0.valid_i = vin && sel == 0;
  assign if1.valid_i = vin && sel == 1;
  assign if2.valid_i = vin && sel == 2;
  assign if0.ready_i = rin;
  assign if1.ready_i = rin;
  assign if2.ready_i = rin;

  trans_validator_multi u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  trans_validator_multi #(.AMT_W(8), .DEPTH(4), .REPORT_REJECTS(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  trans_validator_multi #(.AMT_W(8), .BAL_W(8), .DEPTH(16), .INIT_BAL(200)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  always_comb begin
    o_ready = if0.ready_o; o_valid = if0.valid_o; o_status = if0.status_o;
    o_tag = if0.data_o[8:0]; o_snd = if0.data_o[127 -: 48];
    o_acc = if0.acc_cnt_o; o_rej = if0.rej_cnt_o;
    if (sel == 1) begin
      o_ready = if1.ready_o; o_valid = if1.valid_o; o_status = if1.status_o;
      o_tag = if1.data_o[8:0]; o_snd = if1.data_o[113 -: 48];
      o_acc = if1.acc_cnt_o; o_rej = if1.rej_cnt_o;
    end else if (sel == 2) begin
      o_ready = if2.ready_o; o_valid = if2.valid_o; o_status = if2.status_o;
      o_tag = if2.data_o[8:0]; o_snd = if2.data_o[113 -: 48];
      o_acc = if2.acc_cnt_o; o_rej = if2.rej_cnt_o;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [47:0] s, input logic [47:0] r,
                      input logic [21:0] a, input logic b, input logic [8:0] t);
    int w;
    w = 0;
    sel = k;
    while (!o_ready && w < 200) begin @(negedge clk); w++; end
    if (!o_ready) chk("ready_wait", {63'd0, o_ready}, 64'd1);
    snd = s; rcv = r; amt = a; bs = b; tag = t; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [1:0] st, input logic [8:0] t);
    int w;
    w = 0;
    while (!o_valid && w < 200) begin @(negedge clk); w++; end
    chk({name, "_valid"}, {63'd0, o_valid}, 64'd1);
    chk({name, "_status"}, {62'd0, o_status}, {62'd0, st});
    chk({name, "_tag"}, {55'd0, o_tag}, {55'd0, t});
  endtask

  task automatic expect_silent(input string name, input int n);
    logic saw;
    saw = 1'b0;
    repeat (n) begin @(negedge clk); if (o_valid) saw = 1'b1; end
    chk({name, "_no_report"}, {63'd0, saw}, 64'd0);
  endtask

  task automatic chk_cnt(input string name, input int acc, input int rej);
    @(negedge clk);
    chk({name, "_acc"}, {32'd0, o_acc}, 64'(acc));
    chk({name, "_rej"}, {32'd0, o_rej}, 64'(rej));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; sel = 0; vin = 1'b0; rin = 1'b1;
    snd = '0; rcv = '0; amt = '0; bs = 1'b0; tag = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, o_ready}, 64'd0);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_status", {62'd0, o_status}, 64'd0);
    chk("rst_data", if0.data_o[63:0], 64'd0);
    chk("rst_acc", {32'd0, o_acc}, 64'd0);
    chk("rst_rej", {32'd0, o_rej}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, o_ready}, 64'd1);

    // Default configuration
    send(0, IdA, IdB, 22'd30, 1'b1, 9'd1);
    expect_resp("ab30", StOk, 9'd1);
    chk("ab30_sender", {16'd0, o_snd}, {16'd0, IdA});
    chk_cnt("ab30", 1, 0);
    send(0, IdA, IdB, 22'd71, 1'b0, 9'd2);
    expect_resp("ab71", StFunds, 9'd2);
    chk_cnt("ab71", 1, 1);
    send(0, IdA, IdB, 22'd70, 1'b0, 9'd3);
    expect_resp("ab70", StOk, 9'd3);
    send(0, IdB, IdA, 22'd201, 1'b0, 9'd4);
    expect_resp("ba201", StFunds, 9'd4);
    send(0, IdB, IdA, 22'd200, 1'b0, 9'd5);
    expect_resp("ba200", StOk, 9'd5);
    send(0, IdC, IdC, 22'd50, 1'b0, 9'd6);
    expect_resp("cc50", StOk, 9'd6);
    send(0, IdC, IdA, 22'd101, 1'b0, 9'd7);
    expect_resp("ca101", StFunds, 9'd7);
    send(0, IdC, IdA, 22'd100, 1'b0, 9'd8);
    expect_resp("ca100", StOk, 9'd8);
    send(0, IdB, IdA, 22'd0, 1'b0, 9'd9);
    expect_resp("ba0", StOk, 9'd9);
    chk_cnt("dflt", 6, 3);

    // Downstream backpressure holds the report
    rin = 1'b0;
    send(0, IdA, IdB, 22'd1, 1'b0, 9'd10);
    expect_resp("bp", StOk, 9'd10);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", {63'd0, o_valid}, 64'd1);
      chk("bp_tag_hold", {55'd0, o_tag}, 64'd10);
      chk("bp_ready_low", {63'd0, o_ready}, 64'd0);
    end
    rin = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, o_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, o_ready}, 64'd1);

    // Reset in the middle of a ledger scan
    send(0, IdA, IdC, 22'd1, 1'b0, 9'd11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_silent("midrst", 20);
    chk("midrst_acc", {32'd0, o_acc}, 64'd0);
    chk("midrst_rej", {32'd0, o_rej}, 64'd0);
    // Ledger emptied: A is recreated with 100, so 150 is unaffordable
    send(0, IdA, IdB, 22'd150, 1'b0, 9'd12);
    expect_resp("midrst_empty", StFunds, 9'd12);
    chk_cnt("midrst_after", 0, 1);

    // DEPTH=4, rejects not reported
    send(1, IdA, IdB, 22'd10, 1'b1, 9'd20);
    expect_resp("d4_ab10", StOk, 9'd20);
    send(1, IdA, IdB, 22'd91, 1'b0, 9'd21);
    expect_silent("d4_funds", 30);
    chk_cnt("d4_funds", 1, 1);
    send(1, IdC, IdA, 22'd5, 1'b0, 9'd22);
    expect_resp("d4_ca5", StOk, 9'd22);
    send(1, IdD, IdE, 22'd1, 1'b0, 9'd23);
    expect_silent("d4_full", 30);
    chk_cnt("d4_full", 2, 2);
    send(1, IdD, IdA, 22'd30, 1'b0, 9'd24);
    expect_resp("d4_da30", StOk, 9'd24);
    send(1, IdD, IdB, 22'd71, 1'b0, 9'd25);
    expect_silent("d4_db71", 30);
    send(1, IdD, IdB, 22'd70, 1'b0, 9'd26);
    expect_resp("d4_db70", StOk, 9'd26);
    send(1, IdE, IdA, 22'd1, 1'b0, 9'd27);
    expect_silent("d4_full2", 30);
    chk_cnt("d4_end", 4, 4);

    // BAL_W=8, INIT_BAL=200
    send(2, IdA, IdB, 22'd60, 1'b1, 9'd30);
    expect_resp("b8_ovf", StOvf, 9'd30);
    chk_cnt("b8_ovf", 0, 1);
    send(2, IdA, IdB, 22'd56, 1'b0, 9'd31);
    expect_resp("b8_ovf256", StOvf, 9'd31);
    send(2, IdA, IdB, 22'd55, 1'b0, 9'd32);
    expect_resp("b8_ab55", StOk, 9'd32);
    send(2, IdB, IdA, 22'd100, 1'b0, 9'd33);
    expect_resp("b8_ba100", StOk, 9'd33);
    send(2, IdA, IdB, 22'd246, 1'b0, 9'd34);
    expect_resp("b8_ab246", StFunds, 9'd34);
    chk_cnt("b8_end", 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
